mul_rep_add_seq: RTL
====================

# mul_rep_add_seq

Parametrised sequential unsigned multiplier that computes `product = a * b` by repeated addition. It integrates the operand register, down-counter, accumulator, zero-detect and control FSM into one block with a start/busy/done handshake. It is the width-generic, self-controlled successor of the 16-bit repeated-addition datapath and sits as a slave compute unit behind any sequencer that can wait a data-dependent number of cycles.

## Interface
- `WIDTH`, default 16: operand width in bits; must be ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only while `busy` = 0.
- `a`  in  WIDTH  multiplicand, unsigned; sampled on the accepting edge.
- `b`  in  WIDTH  multiplier, unsigned; sampled on the accepting edge.
- `busy`  out  1  high from the accepting edge until the `done` cycle inclusive.
- `done`  out  1  registered single-cycle pulse; `product` is valid in this cycle.
- `product`  out  2*WIDTH  result register; holds until the next accepted `start`.

## Operation
- **Registers:**
  - A (WIDTH): addend.
  - CNT (WIDTH): down-counter.
  - P (2*WIDTH): accumulator, which drives `product`.
  - `state`.
- **Reset:** `state` = IDLE; `busy`, `done`, P, A and CNT are all 0.
- **IDLE:** on `start` = 1:
  - A ← a, CNT ← b, P ← 0.
  - `state` → RUN.
  - `busy` = 1 from the next cycle.
- **RUN:**
  - If CNT == 0: `state` → DONE.
  - Otherwise: P ← P + zero-extended A, and CNT ← CNT − 1.
- **DONE:**
  - `done` = 1 and `busy` = 1 for exactly one cycle.
  - `state` → IDLE unconditionally.
  - `start` during DONE is ignored.
- **Arithmetic:**
  - The accumulator add is 2*WIDTH wide and cannot overflow, since the maximum result is (2^W−1)^2.
  - CNT never decrements below 0 because the zero test has priority.
- **`start` while `busy`:** ignored; no state change and no queuing.
- **`a`, `b` changes after acceptance:** no effect on the running operation.
- **Zero operand:**
  - b = 0 gives `product` = 0 with minimum latency.
  - a = 0 runs the full b iterations adding 0, unless the swap feature is enabled.
- **Reset mid-operation:** immediate return to IDLE with all outputs 0; the partial product is discarded.

## Timing
- Accepting edge is t0. CNT == 0 is detected at edge t0 + n + 1, where n is the effective counter value (b, or min(a,b) with swap).
- `done` is high in the cycle following edge t0 + n + 1 and drops after edge t0 + n + 2.
- **Latency:** n + 2 rising edges from accept to `done` deasserting; next `start` accepted at edge t0 + n + 3 at the earliest.
- Minimum occupancy (n = 0) is 3 cycles: IDLE-accept, RUN, DONE.
- Worst case without swap: 2^WIDTH + 1 cycles.
- `busy` and `done` are registered decodes of `state`, with no combinational path from `start`.

## Configuration
- **`MUL_OPERAND_SWAP_EN` defined:**
  - On the accepting edge, the larger operand is loaded into A and the smaller into CNT.
  - An unsigned compare `a < b` selects the swap; on a tie, a goes to A and b to CNT.
  - Latency becomes min(a,b) + 2.
- **Not defined:** A ← a and CNT ← b always, with latency b + 2; no comparator is synthesised.
- The product value is identical in both builds.

## Structure
- **Package `mul_pkg`:**
  - `typedef enum` `mul_state_t` {IDLE, RUN, DONE} with a 2-bit encoding.
  - Localparam helper for the product width (2*WIDTH).
- **Sub-module `mul_down_counter`:**
  - Parametrised WIDTH; ports `clk`, `rst_n`, `ld`, `dec`, `din`, `dout`, `eqz`.
  - Load has priority over decrement.
  - `eqz` is combinational on `dout`.
- Accumulator, adder and FSM stay in the top module.

## Test plan
- **Basic:** WIDTH = 16, a = 7, b = 5 → `done` pulses 7 edges after accept (5 + 2), `product` = 35, `busy` high for exactly 7 cycles.
- **Zero:**
  - b = 0, a = 1234 → `product` = 0 after 2 edges.
  - a = 0, b = 3 → `product` = 0 with latency 5 without swap, 2 with `MUL_OPERAND_SWAP_EN`.
- **Max:** WIDTH = 4, a = 15, b = 15 → `product` = 225 (8'hE1), latency 17, no overflow.
- **Busy-ignore:** `start` with a = 3, b = 4; reassert `start` with a = 9, b = 9 during RUN and DONE → single `done`, `product` = 12, the second request is not executed.
- **Back-to-back:** hold `start` high continuously with changing operands → each accept occurs on the edge after the `done` cycle; products are correct and `done` is never two cycles wide.
- **Reset mid-run:** assert `rst_n` = 0 asynchronously at iteration 3 of 10 → `busy`, `done` and `product` go to 0 immediately; after release, a fresh `start` gives a correct result.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the repeated-addition multiplier.
// Optional feature macro: MUL_OPERAND_SWAP_EN (see mul_rep_add_seq).
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_DEFAULT_WIDTH = 16;

    // Product width for a given operand width.
    function automatic int mul_prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul_down_counter.sv
// Loadable down-counter with zero detect.
// Load wins over decrement; eqz follows dout combinationally.
module mul_down_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             dec,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             eqz
);

    logic [WIDTH-1:0] r_cnt;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ld) begin
            r_cnt <= din;
        end else if (dec) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign dout = r_cnt;
    assign eqz  = (r_cnt == '0);

endmodule

// File: rtl/mul_rep_add_seq.sv
// Sequential unsigned multiplier by repeated addition, start/busy/done.
// Define MUL_OPERAND_SWAP_EN to count down the smaller operand.
module mul_rep_add_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic                          busy,
    output logic                          done,
    output logic [mul_prod_w(WIDTH)-1:0]  product
);

    localparam int PW = mul_prod_w(WIDTH);

    mul_state_t       r_state;
    mul_state_t       w_next;
    logic [WIDTH-1:0] r_a;
    logic [PW-1:0]    r_p;
    logic             r_busy;
    logic             r_done;

    logic             w_ld;
    logic             w_dec;
    logic             w_eqz;
    logic [WIDTH-1:0] w_cnt;
    logic [WIDTH-1:0] w_a_ld;
    logic [WIDTH-1:0] w_cnt_ld;

`ifdef MUL_OPERAND_SWAP_EN
    logic w_swap;
    assign w_swap   = (a < b);
    assign w_a_ld   = w_swap ? b : a;
    assign w_cnt_ld = w_swap ? a : b;
`else
    assign w_a_ld   = a;
    assign w_cnt_ld = b;
`endif

    mul_down_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (w_ld),
        .dec   (w_dec),
        .din   (w_cnt_ld),
        .dout  (w_cnt),
        .eqz   (w_eqz)
    );

    // Next-state and datapath strobes; zero test beats decrement.
    always_comb begin
        w_next = r_state;
        w_ld   = 1'b0;
        w_dec  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_ld   = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_eqz) begin
                    w_next = DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Addend captured on the accepting edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
        end else if (w_ld) begin
            r_a <= w_a_ld;
        end
    end

    // Accumulator: cleared on accept, adds the addend per iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else if (w_ld) begin
            r_p <= '0;
        end else if (w_dec) begin
            r_p <= r_p + {{(PW-WIDTH){1'b0}}, r_a};
        end
    end

    // Handshake flags registered from the next state, so no start path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == DONE);
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_p;

    logic w_unused;
    assign w_unused = ^w_cnt;

endmodule
